// File: rtl/serial_ripple_borrow_sub4b_pkg.sv
// Shared constants and FSM state type for the serial 4-bit ripple-borrow subtractor.
package sub4b_pkg;

    localparam int unsigned SUB_W = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/serial_ripple_borrow_sub4b_full_subtractor_1b.sv
// One-bit combinational full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor_1b (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign d     = w_axb ^ bin;
    assign bout  = (~a & b) | (bin & ~w_axb);

endmodule

// File: rtl/serial_ripple_borrow_sub4b.sv
// Bit-serial 4-bit subtractor D = A - B - Bin, LSB first, one bit per clock,
// with a start/busy/done handshake and a single registered borrow stage.
module serial_ripple_borrow_sub4b
    import sub4b_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic start,
    input  logic A3,
    input  logic A2,
    input  logic A1,
    input  logic A0,
    input  logic B3,
    input  logic B2,
    input  logic B1,
    input  logic B0,
    input  logic Bin,
    output logic busy,
    output logic done,
    output logic D3,
    output logic D2,
    output logic D1,
    output logic D0,
    output logic Bout
);

    sub_state_t       r_state;
    sub_state_t       w_state_next;
    logic [SUB_W-1:0] r_a;
    logic [SUB_W-1:0] r_b;
    logic [SUB_W-1:0] r_d;
    logic             r_br;
    logic             r_bout;
    logic [IDX_W-1:0] r_idx;

    logic [SUB_W-1:0] w_a_in;
    logic [SUB_W-1:0] w_b_in;
    logic             w_accept;
    logic             w_last_bit;
    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_d_bit;
    logic             w_bout_bit;

    assign w_a_in     = {A3, A2, A1, A0};
    assign w_b_in     = {B3, B2, B1, B0};
    assign w_a_bit    = r_a[r_idx];
    assign w_b_bit    = r_b[r_idx];
    assign w_last_bit = (r_idx == IDX_W'(SUB_W - 1));
    assign w_accept   = en && start && ((r_state == IDLE) || (r_state == DONE));

    full_subtractor_1b u_fs (
        .a    (w_a_bit),
        .b    (w_b_bit),
        .bin  (r_br),
        .d    (w_d_bit),
        .bout (w_bout_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!en) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_next = start ? SUB : IDLE;
                SUB:     w_state_next = w_last_bit ? DONE : SUB;
                DONE:    w_state_next = start ? SUB : IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Enable-low clears only the visible results; operands survive until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_br   <= 1'b0;
            r_idx  <= '0;
            r_d    <= '0;
            r_bout <= 1'b0;
        end else if (!en) begin
            r_d    <= '0;
            r_bout <= 1'b0;
        end else if (w_accept) begin
            r_a    <= w_a_in;
            r_b    <= w_b_in;
            r_br   <= Bin;
            r_idx  <= '0;
            r_d    <= '0;
            r_bout <= 1'b0;
        end else if (r_state == SUB) begin
            r_d[r_idx] <= w_d_bit;
            r_br       <= w_bout_bit;
            r_idx      <= r_idx + 1'b1;
            if (w_last_bit) begin
                r_bout <= w_bout_bit;
            end
        end
    end

    assign busy = (r_state == SUB);
    assign done = (r_state == DONE);
    assign D3   = r_d[3];
    assign D2   = r_d[2];
    assign D1   = r_d[1];
    assign D0   = r_d[0];
    assign Bout = r_bout;

endmodule

// File: tb/tb_serial_ripple_borrow_sub4b.sv
// Directed self-checking bench for serial_ripple_borrow_sub4b.
module tb_serial_ripple_borrow_sub4b;

    logic clk;
    logic rst;
    logic en;
    logic start;
    logic A3, A2, A1, A0;
    logic B3, B2, B1, B0;
    logic Bin;
    logic busy;
    logic done;
    logic D3, D2, D1, D0;
    logic Bout;

    int checks;
    int errors;

    serial_ripple_borrow_sub4b dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .start (start),
        .A3    (A3),
        .A2    (A2),
        .A1    (A1),
        .A0    (A0),
        .B3    (B3),
        .B2    (B2),
        .B1    (B1),
        .B0    (B0),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .D3    (D3),
        .D2    (D2),
        .D1    (D1),
        .D0    (D0),
        .Bout  (Bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] get_d();
        return {D3, D2, D1, D0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [3:0] a, input logic [3:0] b, input logic bin);
        {A3, A2, A1, A0} = a;
        {B3, B2, B1, B0} = b;
        Bin = bin;
    endtask

    // Drives one start and waits (bounded) for done; reports observations only.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                         output logic [3:0] d, output logic bout,
                         output int edges, output int busy_cnt, output int overlap);
        set_ops(a, b, bin);
        start = 1'b1;
        tick();
        start = 1'b0;
        edges    = 1;
        busy_cnt = busy ? 1 : 0;
        overlap  = (busy && done) ? 1 : 0;
        while (!done && edges < 12) begin
            tick();
            edges++;
            if (busy) busy_cnt++;
            if (busy && done) overlap++;
        end
        d    = get_d();
        bout = Bout;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; start = 1'b0;
        set_ops(4'd0, 4'd0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, get_d(), Bout} !== 7'b0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b D=%b Bout=%b, required all 0", busy, done, get_d(), Bout);
        end
    endtask

    task automatic test_basic();
        logic [3:0] d;
        logic bout;
        int edges, bc, ov;
        do_op(4'd9, 4'd3, 1'b0, d, bout, edges, bc, ov);
        checks++;
        if (edges !== 5) begin
            errors++;
            $display("FAIL basic_latency: edges=%0d, required 5", edges);
        end
        checks++;
        if (bc !== 4) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, required 4", bc);
        end
        checks++;
        if (ov !== 0) begin
            errors++;
            $display("FAIL basic_busy_done_overlap: got %0d, required 0", ov);
        end
        checks++;
        if ({d, bout} !== {4'b0110, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: D=%b Bout=%b, required D=0110 Bout=0", d, bout);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b one cycle later, required 0", done);
        end
        tick();
        tick();
        checks++;
        if ({get_d(), Bout, busy} !== {4'b0110, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_hold: D=%b Bout=%b busy=%b, required D=0110 Bout=0 busy=0", get_d(), Bout, busy);
        end
    endtask

    task automatic test_directed();
        logic [3:0] va [3];
        logic [3:0] vb [3];
        logic       vbin [3];
        logic [3:0] ed [3];
        logic       eb [3];
        logic [3:0] d;
        logic bout;
        int edges, bc, ov;
        va[0] = 4'd3;  vb[0] = 4'd9;  vbin[0] = 1'b0; ed[0] = 4'b1010; eb[0] = 1'b1;
        va[1] = 4'd0;  vb[1] = 4'd0;  vbin[1] = 1'b1; ed[1] = 4'b1111; eb[1] = 1'b1;
        va[2] = 4'd15; vb[2] = 4'd15; vbin[2] = 1'b1; ed[2] = 4'b1111; eb[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vbin[i], d, bout, edges, bc, ov);
            checks++;
            if ({d, bout} !== {ed[i], eb[i]} || edges !== 5) begin
                errors++;
                $display("FAIL directed_%0d: D=%b Bout=%b edges=%0d, required D=%b Bout=%b edges=5",
                         i, d, bout, edges, ed[i], eb[i]);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] d;
        logic bout;
        int edges, bc, ov;
        int ref_diff;
        logic [3:0] exp_d;
        logic exp_b;
        // Each call starts during the previous op's DONE cycle.
        for (int unsigned n = 0; n < 512; n++) begin
            logic [3:0] a, b;
            logic bi;
            a  = n[8:5];
            b  = n[4:1];
            bi = n[0];
            ref_diff = int'(a) - int'(b) - int'(bi);
            exp_d = ref_diff[3:0];
            exp_b = (ref_diff < 0);
            do_op(a, b, bi, d, bout, edges, bc, ov);
            checks++;
            if ({d, bout} !== {exp_d, exp_b}) begin
                errors++;
                $display("FAIL exhaustive A=%0d B=%0d Bin=%0d: D=%b Bout=%b, required D=%b Bout=%b",
                         a, b, bi, d, bout, exp_d, exp_b);
            end
            checks++;
            if (edges !== 5 || bc !== 4 || ov !== 0) begin
                errors++;
                $display("FAIL exhaustive_timing A=%0d B=%0d Bin=%0d: edges=%0d busy=%0d overlap=%0d, required 5/4/0",
                         a, b, bi, edges, bc, ov);
            end
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int edges;
        set_ops(4'd12, 4'd5, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        set_ops(4'd1, 4'd1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 3;
        while (!done && edges < 12) begin
            tick();
            edges++;
        end
        checks++;
        if ({get_d(), Bout} !== {4'b0111, 1'b0} || edges !== 5) begin
            errors++;
            $display("FAIL start_ignored: D=%b Bout=%b edges=%0d, required D=0111 Bout=0 edges=5", get_d(), Bout, edges);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_no_restart: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_en_abort();
        logic [3:0] d;
        logic bout;
        int edges, bc, ov;
        int seen;
        set_ops(4'd8, 4'd1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        en = 1'b0;
        tick();
        checks++;
        if ({busy, done, get_d(), Bout} !== 7'b0) begin
            errors++;
            $display("FAIL en_abort_clear: busy=%b done=%b D=%b Bout=%b, required all 0", busy, done, get_d(), Bout);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL en_abort_quiet: busy/done cycles=%0d, required 0", seen);
        end
        en = 1'b1;
        do_op(4'd8, 4'd1, 1'b0, d, bout, edges, bc, ov);
        checks++;
        if ({d, bout} !== {4'b0111, 1'b0} || edges !== 5) begin
            errors++;
            $display("FAIL en_recover: D=%b Bout=%b edges=%0d, required D=0111 Bout=0 edges=5", d, bout, edges);
        end
        tick();
    endtask

    task automatic test_rst_mid();
        logic [3:0] d;
        logic bout;
        int edges, bc, ov;
        int seen;
        set_ops(4'd6, 4'd2, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, done, get_d(), Bout} !== 7'b0) begin
            errors++;
            $display("FAIL rst_mid_clear: busy=%b done=%b D=%b Bout=%b, required all 0", busy, done, get_d(), Bout);
        end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: busy/done cycles=%0d, required 0", seen);
        end
        do_op(4'd6, 4'd2, 1'b0, d, bout, edges, bc, ov);
        checks++;
        if ({d, bout} !== {4'b0100, 1'b0} || edges !== 5) begin
            errors++;
            $display("FAIL rst_recover: D=%b Bout=%b edges=%0d, required D=0100 Bout=0 edges=5", d, bout, edges);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_directed();
        test_back_to_back();
        test_start_ignored();
        test_en_abort();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
